// File: rtl/serdes_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serdes_link_ctrl
// Purpose  : Bring-up and supervision controller for one CC_SERDES lane.
//            Sequences the lane reset, waits for reset-done and comma
//            alignment, qualifies the link as stable, watches for alignment
//            loss / buffer errors and retries bring-up a bounded number of
//            times before declaring failure. Single clock domain (ref_clk).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   ref_clk               in   clock
//   rst                   in   synchronous active-high reset
//   enable_i              in   request bring-up; low forces IDLE
//   tx_reset_done_i       in   async, SERDES TX reset done
//   rx_reset_done_i       in   async, SERDES RX reset done
//   rx_byte_is_aligned_i  in   async, comma alignment achieved
//   rx_byte_realign_i     in   async, realignment occurred
//   rx_buf_err_i          in   async, RX elastic buffer error
//   tx_buf_err_i          in   async, TX buffer error
//   trx_rst_o             out  TX/RX/PLL reset to the SERDES
//   link_up_o             out  high only in LINK_UP
//   link_fail_o           out  high only in FAIL
//   state_o        [2:0]  out  current state encoding
//   retry_cnt_o    [1:0]  out  retries used in the current bring-up
//   err_cnt_o     [15:0]  out  saturating error-event count
// ============================================================================
module serdes_link_ctrl #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int STABLE_CYCLES   = 256,
    parameter int MAX_RETRIES     = 3
) (
    input  logic        ref_clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        tx_reset_done_i,
    input  logic        rx_reset_done_i,
    input  logic        rx_byte_is_aligned_i,
    input  logic        rx_byte_realign_i,
    input  logic        rx_buf_err_i,
    input  logic        tx_buf_err_i,
    output logic        trx_rst_o,
    output logic        link_up_o,
    output logic        link_fail_o,
    output logic [2:0]  state_o,
    output logic [1:0]  retry_cnt_o,
    output logic [15:0] err_cnt_o
);

    // Timer must be able to hold the largest terminal count of any state.
    localparam int c_TMR_MAX =
        (TIMEOUT_CYCLES > STABLE_CYCLES) ?
            ((TIMEOUT_CYCLES > RST_HOLD_CYCLES) ? TIMEOUT_CYCLES : RST_HOLD_CYCLES) :
            ((STABLE_CYCLES  > RST_HOLD_CYCLES) ? STABLE_CYCLES  : RST_HOLD_CYCLES);
    localparam int c_TMR_W = $clog2(c_TMR_MAX + 1);

    localparam logic [c_TMR_W-1:0] c_RST_LAST = c_TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_STB_LAST = c_TMR_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]         c_MAX_RTY  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_RESET         = 3'd1,
        S_WAIT_RST_DONE = 3'd2,
        S_WAIT_ALIGN    = 3'd3,
        S_STABLE        = 3'd4,
        S_LINK_UP       = 3'd5,
        S_FAIL          = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the six asynchronous status inputs.
    // Bit map: 0 tx_done, 1 rx_done, 2 aligned, 3 realign, 4 rx_buf_err,
    //          5 tx_buf_err.
    // ------------------------------------------------------------------
    logic [5:0] w_async;
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;

    assign w_async = {tx_buf_err_i, rx_buf_err_i, rx_byte_realign_i,
                      rx_byte_is_aligned_i, rx_reset_done_i, tx_reset_done_i};

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
        end
    end

    logic w_rst_done;
    logic w_aligned;
    logic w_err_lvl;
    logic r_err_lvl_q;
    logic w_err_evt;

    assign w_rst_done = r_sync2[0] & r_sync2[1];
    assign w_aligned  = r_sync2[2];
    assign w_err_lvl  = |r_sync2[5:3];
    // Only the rising edge counts, so a held error level is one event.
    assign w_err_evt  = w_err_lvl & ~r_err_lvl_q;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_retry;
    logic [1:0]           w_retry_nxt;
    logic                 w_retry_req;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 w_link_fault;

    assign w_link_fault = ~w_aligned | ~w_rst_done | w_err_evt;

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_retry_req = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_retry_nxt = 2'd0;
                if (enable_i) begin
                    w_state_nxt = S_RESET;
                end
            end
            S_RESET: begin
                if (r_timer == c_RST_LAST) begin
                    w_state_nxt = S_WAIT_RST_DONE;
                end
            end
            S_WAIT_RST_DONE: begin
                // Success is tested first so it wins on the timeout cycle.
                if (w_rst_done) begin
                    w_state_nxt = S_WAIT_ALIGN;
                end else if (r_timer == c_TO_LAST) begin
                    w_retry_req = 1'b1;
                end
            end
            S_WAIT_ALIGN: begin
                if (w_aligned) begin
                    w_state_nxt = S_STABLE;
                end else if (r_timer == c_TO_LAST) begin
                    w_retry_req = 1'b1;
                end
            end
            S_STABLE: begin
                if (w_link_fault) begin
                    w_retry_req = 1'b1;
                end else if (r_timer == c_STB_LAST) begin
                    w_state_nxt = S_LINK_UP;
                    w_retry_nxt = 2'd0;
                end
            end
            S_LINK_UP: begin
                if (w_link_fault) begin
                    w_retry_req = 1'b1;
                end
            end
            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_retry_nxt = 2'd0;
            end
        endcase

        if (w_retry_req) begin
            if (r_retry == c_MAX_RTY) begin
                w_state_nxt = S_FAIL;
            end else begin
                w_state_nxt = S_RESET;
                w_retry_nxt = r_retry + 2'd1;
            end
        end

        if (!enable_i) begin
            w_state_nxt = S_IDLE;
            w_retry_nxt = 2'd0;
        end
    end

    logic w_trx_rst_nxt;
    assign w_trx_rst_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET) ||
                           (w_state_nxt == S_FAIL);

    logic r_trx_rst;
    logic r_link_up;
    logic r_link_fail;

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_retry     <= 2'd0;
            r_timer     <= '0;
            r_trx_rst   <= 1'b1;
            r_link_up   <= 1'b0;
            r_link_fail <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_retry     <= w_retry_nxt;
            r_trx_rst   <= w_trx_rst_nxt;
            r_link_up   <= (w_state_nxt == S_LINK_UP);
            r_link_fail <= (w_state_nxt == S_FAIL);
            // Timer restarts on every state change and saturates in the
            // untimed states so it can never wrap into a false match.
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating error-event counter, active in every state.
    // ------------------------------------------------------------------
    logic [15:0] r_err_cnt;

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            r_err_lvl_q <= 1'b0;
            r_err_cnt   <= 16'd0;
        end else begin
            r_err_lvl_q <= w_err_lvl;
            if (w_err_evt && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign trx_rst_o   = r_trx_rst;
    assign link_up_o   = r_link_up;
    assign link_fail_o = r_link_fail;
    assign state_o     = r_state;
    assign retry_cnt_o = r_retry;
    assign err_cnt_o   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serdes_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serdes_link_ctrl
// Purpose  : Self-checking bench for serdes_link_ctrl. Stimulus pushes the
//            expected state transitions and error-count values into queues;
//            a monitor pops and compares whenever state_o or err_cnt_o moves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serdes_link_ctrl;

    logic        ref_clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        tx_reset_done_i;
    logic        rx_reset_done_i;
    logic        rx_byte_is_aligned_i;
    logic        rx_byte_realign_i;
    logic        rx_buf_err_i;
    logic        tx_buf_err_i;
    logic        trx_rst_o;
    logic        link_up_o;
    logic        link_fail_o;
    logic [2:0]  state_o;
    logic [1:0]  retry_cnt_o;
    logic [15:0] err_cnt_o;

    always #5 ref_clk = ~ref_clk;

    serdes_link_ctrl #(
        .RST_HOLD_CYCLES (4),
        .TIMEOUT_CYCLES  (32),
        .STABLE_CYCLES   (8),
        .MAX_RETRIES     (2)
    ) dut (
        .ref_clk              (ref_clk),
        .rst                  (rst),
        .enable_i             (enable_i),
        .tx_reset_done_i      (tx_reset_done_i),
        .rx_reset_done_i      (rx_reset_done_i),
        .rx_byte_is_aligned_i (rx_byte_is_aligned_i),
        .rx_byte_realign_i    (rx_byte_realign_i),
        .rx_buf_err_i         (rx_buf_err_i),
        .tx_buf_err_i         (tx_buf_err_i),
        .trx_rst_o            (trx_rst_o),
        .link_up_o            (link_up_o),
        .link_fail_o          (link_fail_o),
        .state_o              (state_o),
        .retry_cnt_o          (retry_cnt_o),
        .err_cnt_o            (err_cnt_o)
    );

    // Expected transition: new state, retry count and flags on entry, plus
    // the number of cycles spent in the state being left (-1 = unchecked).
    typedef struct {
        logic [2:0] st;
        logic [1:0] rc;
        logic       trx;
        logic       lu;
        logic       lf;
        int         dwell;
    } exp_t;

    exp_t        q_st[$];
    logic [15:0] q_err[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_on  = 1'b0;

    task automatic push_st(input logic [2:0] st, input logic [1:0] rc, input int dwell);
        exp_t e;
        e.st    = st;
        e.rc    = rc;
        e.trx   = (st == 3'd0) || (st == 3'd1) || (st == 3'd6);
        e.lu    = (st == 3'd5);
        e.lf    = (st == 3'd6);
        e.dwell = dwell;
        q_st.push_back(e);
    endtask

    task automatic push_err(input logic [15:0] v);
        q_err.push_back(v);
    endtask

    // Fault from LINK_UP followed by a fast re-bring-up (status already good).
    task automatic push_retry_cycle(input int lu_dwell, input logic [1:0] rc);
        push_st(3'd1, rc, lu_dwell);
        push_st(3'd2, rc, 4);
        push_st(3'd3, rc, 1);
        push_st(3'd4, rc, 1);
        push_st(3'd5, 2'd0, 8);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while ((state_o !== s) && (n < budget)) begin
            @(negedge ref_clk);
            n++;
        end
        if (state_o !== s) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles",
                     state_o, s, budget);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        logic [2:0]  last_st;
        logic [15:0] last_err;
        int          cyc;
        int          last_chg;
        exp_t        e;
        wait (mon_on);
        last_st  = state_o;
        last_err = err_cnt_o;
        cyc      = 0;
        last_chg = 0;
        forever begin
            @(negedge ref_clk);
            cyc++;
            if (state_o !== last_st) begin
                n_tests++;
                if (q_st.size() == 0) begin
                    n_fail++;
                    $display("FAIL trans: unexpected move %0d->%0d", last_st, state_o);
                end else begin
                    e = q_st.pop_front();
                    if ((state_o !== e.st) || (retry_cnt_o !== e.rc) ||
                        (trx_rst_o !== e.trx) || (link_up_o !== e.lu) ||
                        (link_fail_o !== e.lf) ||
                        ((e.dwell >= 0) && ((cyc - last_chg) != e.dwell))) begin
                        n_fail++;
                        $display("FAIL trans: got st=%0d rc=%0d trx=%0b lu=%0b lf=%0b dwell=%0d expected st=%0d rc=%0d trx=%0b lu=%0b lf=%0b dwell=%0d",
                                 state_o, retry_cnt_o, trx_rst_o, link_up_o, link_fail_o,
                                 cyc - last_chg, e.st, e.rc, e.trx, e.lu, e.lf, e.dwell);
                    end
                end
                last_st  = state_o;
                last_chg = cyc;
            end
            if (err_cnt_o !== last_err) begin
                n_tests++;
                if (q_err.size() == 0) begin
                    n_fail++;
                    $display("FAIL err_cnt: unexpected change to %h", err_cnt_o);
                end else if (err_cnt_o !== q_err[0]) begin
                    n_fail++;
                    $display("FAIL err_cnt: got %h expected %h", err_cnt_o, q_err[0]);
                    void'(q_err.pop_front());
                end else begin
                    void'(q_err.pop_front());
                end
                last_err = err_cnt_o;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; enable_i = 1'b0;
        tx_reset_done_i = 1'b0; rx_reset_done_i = 1'b0;
        rx_byte_is_aligned_i = 1'b0; rx_byte_realign_i = 1'b0;
        rx_buf_err_i = 1'b0; tx_buf_err_i = 1'b0;
        repeat (3) @(negedge ref_clk);

        chk("reset state",  int'(state_o),     0);
        chk("reset trx",    int'(trx_rst_o),   1);
        chk("reset lu",     int'(link_up_o),   0);
        chk("reset lf",     int'(link_fail_o), 0);
        chk("reset retry",  int'(retry_cnt_o), 0);
        chk("reset err",    int'(err_cnt_o),   0);
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge ref_clk);

        // 1. Nominal bring-up
        push_st(3'd1, 2'd0, -1);
        push_st(3'd2, 2'd0, 4);
        enable_i = 1'b1;
        wait_state(3'd2, 10);
        repeat (10) @(negedge ref_clk);
        push_st(3'd3, 2'd0, 13);
        tx_reset_done_i = 1'b1; rx_reset_done_i = 1'b1;
        repeat (5) @(negedge ref_clk);
        push_st(3'd4, 2'd0, 5);
        push_st(3'd5, 2'd0, 8);
        rx_byte_is_aligned_i = 1'b1;
        wait_state(3'd5, 30);

        // 3. One-cycle alignment loss in LINK_UP
        push_retry_cycle(3, 2'd1);
        rx_byte_is_aligned_i = 1'b0;
        @(negedge ref_clk);
        rx_byte_is_aligned_i = 1'b1;
        wait_state(3'd1, 10);
        wait_state(3'd5, 40);

        // 4. Error counting: three realign pulses, then one held tx error
        for (int i = 0; i < 3; i++) begin
            push_err(16'(i + 1));
            push_retry_cycle(3, 2'd1);
            rx_byte_realign_i = 1'b1;
            @(negedge ref_clk);
            rx_byte_realign_i = 1'b0;
            wait_state(3'd1, 10);
            wait_state(3'd5, 40);
        end
        push_err(16'd4);
        push_retry_cycle(3, 2'd1);
        tx_buf_err_i = 1'b1;
        repeat (20) @(negedge ref_clk);
        tx_buf_err_i = 1'b0;
        wait_state(3'd5, 40);
        repeat (5) @(negedge ref_clk);

        // 2. Reset-done never arrives: three attempts, then FAIL
        push_st(3'd0, 2'd0, -1);
        enable_i = 1'b0;
        tx_reset_done_i = 1'b0; rx_reset_done_i = 1'b0;
        rx_byte_is_aligned_i = 1'b0;
        wait_state(3'd0, 5);
        repeat (4) @(negedge ref_clk);
        push_st(3'd1, 2'd0, -1);
        push_st(3'd2, 2'd0, 4);
        push_st(3'd1, 2'd1, 32);
        push_st(3'd2, 2'd1, 4);
        push_st(3'd1, 2'd2, 32);
        push_st(3'd2, 2'd2, 4);
        push_st(3'd6, 2'd2, 32);
        enable_i = 1'b1;
        wait_state(3'd6, 200);
        repeat (3) @(negedge ref_clk);
        push_st(3'd0, 2'd0, -1);
        enable_i = 1'b0;
        wait_state(3'd0, 5);

        // 5. Alignment seen exactly on the timeout cycle of WAIT_ALIGN
        tx_reset_done_i = 1'b1; rx_reset_done_i = 1'b1;
        repeat (4) @(negedge ref_clk);
        push_st(3'd1, 2'd0, -1);
        push_st(3'd2, 2'd0, 4);
        push_st(3'd3, 2'd0, 1);
        push_st(3'd4, 2'd0, 32);
        push_st(3'd5, 2'd0, 8);
        enable_i = 1'b1;
        wait_state(3'd3, 20);
        repeat (29) @(negedge ref_clk);
        rx_byte_is_aligned_i = 1'b1;
        wait_state(3'd5, 30);

        // Saturation of the error counter, exercised from IDLE
        push_st(3'd0, 2'd0, 1);
        enable_i = 1'b0;
        wait_state(3'd0, 5);
        push_err(16'hFFFE);
        force dut.r_err_cnt = 16'hFFFE;
        @(negedge ref_clk);
        release dut.r_err_cnt;
        repeat (2) @(negedge ref_clk);
        push_err(16'hFFFF);
        for (int i = 0; i < 2; i++) begin
            rx_byte_realign_i = 1'b1;
            @(negedge ref_clk);
            rx_byte_realign_i = 1'b0;
            repeat (5) @(negedge ref_clk);
        end
        chk("err saturate", int'(err_cnt_o), 32'h0000FFFF);
        chk("idle state",   int'(state_o),   0);

        // 6a. rst pulse while in STABLE
        push_st(3'd1, 2'd0, -1);
        push_st(3'd2, 2'd0, 4);
        push_st(3'd3, 2'd0, 1);
        push_st(3'd4, 2'd0, 1);
        push_st(3'd0, 2'd0, 1);
        push_err(16'h0000);
        enable_i = 1'b1;
        wait_state(3'd4, 20);
        rst = 1'b1;
        @(negedge ref_clk);
        rst = 1'b0;
        enable_i = 1'b0;
        chk("rst state", int'(state_o),     0);
        chk("rst trx",   int'(trx_rst_o),   1);
        chk("rst retry", int'(retry_cnt_o), 0);
        chk("rst err",   int'(err_cnt_o),   0);
        repeat (4) @(negedge ref_clk);

        // 6b. enable dropped in WAIT_ALIGN
        rx_byte_is_aligned_i = 1'b0;
        repeat (4) @(negedge ref_clk);
        push_st(3'd1, 2'd0, -1);
        push_st(3'd2, 2'd0, 4);
        push_st(3'd3, 2'd0, 1);
        push_st(3'd0, 2'd0, 1);
        enable_i = 1'b1;
        wait_state(3'd3, 20);
        enable_i = 1'b0;
        @(negedge ref_clk);
        chk("en drop state", int'(state_o),     0);
        chk("en drop trx",   int'(trx_rst_o),   1);
        chk("en drop retry", int'(retry_cnt_o), 0);
        repeat (3) @(negedge ref_clk);

        chk("trans queue drained", q_st.size(),  0);
        chk("err queue drained",   q_err.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
